// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that hands one of NREQ requesters at a time
// to a single spi_master. The four-state FSM is IDLE, LAUNCH, BUSY and DONE.
// Every output is registered.
// The optional BUSY timeout is built only when SPI_ARB_TIMEOUT_EN is defined.
// spi_pkg is kept in this file so the block stays self-contained.

package spi_pkg;
    localparam int DWIDTH = 8;
    localparam int AWIDTH = 7;
    localparam int FW     = DWIDTH + AWIDTH + 5;
endpackage

module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*FW-1:0]   req_data,
    input  logic [NREQ*2-1:0]    req_cfg,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [AWIDTH-1:0]    rsp_addr,
    output logic [DWIDTH-1:0]    rsp_data,
    output logic                 master_en,
    output logic [FW-1:0]        driver_data,
    output logic [1:0]           driver_cfg,
    input  logic                 driver_read,
    input  logic [AWIDTH-1:0]    spi_slv_addr,
    input  logic [DWIDTH-1:0]    spi_slv_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       last_q, last_d;
    logic [PW-1:0]       sel_q, sel_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                master_en_q, master_en_d;
    logic [FW-1:0]       drv_data_q, drv_data_d;
    logic [1:0]          drv_cfg_q, drv_cfg_d;
    logic [AWIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [PW-1:0]       win;
    logic                found;
    logic                tmo;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // BUSY-cycle counter; tmo fires in the TIMEOUT_CYC-th BUSY cycle
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == LAUNCH)    cnt_d = '0;
        else if (state_q == BUSY) cnt_d = cnt_q + 1'b1;
    end
    assign tmo = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Counter and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    localparam int unused_tmo = TIMEOUT_CYC;
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    // Round-robin pick: scan upward starting one past the last granted index
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(last_q) + 1 + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; completion strobe beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = LAUNCH;
            LAUNCH:  state_d = BUSY;
            BUSY:    if (driver_read || tmo) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: compute next register values for all outputs
    always_comb begin
        last_d      = last_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        master_en_d = 1'b0;
        drv_data_d  = drv_data_q;
        drv_cfg_d   = drv_cfg_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    sel_d        = win;
                    gnt_d[win]   = 1'b1;
                    master_en_d  = 1'b1;
                    drv_data_d   = req_data[int'(win)*FW +: FW];
                    drv_cfg_d    = req_cfg[int'(win)*2 +: 2];
                end
            end
            BUSY: begin
                if (driver_read) begin
                    rsp_addr_d    = spi_slv_addr;
                    rsp_data_d    = spi_slv_data;
                    done_d[sel_q] = 1'b1;
                end else if (tmo) begin
                    rsp_addr_d    = '0;
                    rsp_data_d    = '0;
                    done_d[sel_q] = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d         = 1'b1;
`endif
                end
            end
            DONE: begin
                gnt_d  = '0;
                last_d = sel_q;
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= PW'(NREQ - 1);
            sel_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            master_en_q <= 1'b0;
            drv_data_q  <= '0;
            drv_cfg_q   <= '0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            last_q      <= last_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            master_en_q <= master_en_d;
            drv_data_q  <= drv_data_d;
            drv_cfg_q   <= drv_cfg_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign master_en   = master_en_q;
    assign driver_data = drv_data_q;
    assign driver_cfg  = drv_cfg_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter. A transaction-level model tracks the owner,
// the cycles since launch and the round-robin pointer.
// Every DUT output is compared against the model once per clock.
// Directed scenarios pin the model down with literal expectations.
// A randomized phase follows the directed scenarios.
// Define SPI_ARB_TIMEOUT_EN to exercise the timeout.

module tb_spi_arbiter;
    import spi_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 16;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*FW-1:0]  req_data = '0;
    logic [NREQ*2-1:0]   req_cfg = '0;
    logic [NREQ-1:0]     gnt, done;
    logic                err, master_en;
    logic [AWIDTH-1:0]   rsp_addr;
    logic [DWIDTH-1:0]   rsp_data;
    logic [FW-1:0]       driver_data;
    logic [1:0]          driver_cfg;
    logic                driver_read = 1'b0;
    logic [AWIDTH-1:0]   spi_slv_addr = '0;
    logic [DWIDTH-1:0]   spi_slv_data = '0;

    int vectors = 0;
    int miscompares = 0;

    spi_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_cfg(req_cfg),
        .gnt(gnt), .done(done), .err(err), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .master_en(master_en), .driver_data(driver_data), .driver_cfg(driver_cfg),
        .driver_read(driver_read), .spi_slv_addr(spi_slv_addr), .spi_slv_data(spi_slv_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    int                m_owner = -1;   // -1: nobody holds the bus
    int                m_age   = 0;    // 0 = launch cycle, n = n-th busy cycle
    int                m_last  = NREQ - 1;
    bit                m_fin   = 0;    // in the completion cycle
    bit                m_err   = 0;
    logic [FW-1:0]     e_dd = '0;
    logic [1:0]        e_dc = '0;
    logic [AWIDTH-1:0] e_ra = '0;
    logic [DWIDTH-1:0] e_rd = '0;
    logic [NREQ-1:0]   e_gnt, e_done;

    int qg[$];   // granted index observed at each master_en
    int qd[$];   // index observed at each done pulse

    // Model step at each edge, then compare DUT outputs shortly after it
    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_last = NREQ - 1; m_fin = 0; m_err = 0;
            e_dd = '0; e_dc = '0; e_ra = '0; e_rd = '0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req[(m_last + 1 + k) % NREQ]) m_owner = (m_last + 1 + k) % NREQ;
                m_age = 0;
                e_dd  = req_data[m_owner*FW +: FW];
                e_dc  = req_cfg[m_owner*2 +: 2];
            end
        end else if (m_fin) begin
            m_last = m_owner; m_owner = -1; m_fin = 0; m_err = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (driver_read) begin
            m_fin = 1; m_err = 0; e_ra = spi_slv_addr; e_rd = spi_slv_data;
        end else if (TMO_EN && m_age == TMO) begin
            m_fin = 1; m_err = 1; e_ra = '0; e_rd = '0;
        end else begin
            m_age++;
        end
        e_gnt  = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
        e_done = m_fin ? e_gnt : '0;
        #1;
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("done", 64'(done), 64'(e_done));
        chk("master_en", 64'(master_en), 64'(m_owner >= 0 && m_age == 0 && !m_fin));
        chk("err", 64'(err), 64'(m_fin && m_err));
        chk("driver_data", 64'(driver_data), 64'(e_dd));
        chk("driver_cfg", 64'(driver_cfg), 64'(e_dc));
        chk("rsp_addr", 64'(rsp_addr), 64'(e_ra));
        chk("rsp_data", 64'(rsp_data), 64'(e_rd));
        if (master_en) qg.push_back(oh2i(gnt));
        if (done != 0) qd.push_back(oh2i(done));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*FW +: FW] = FW'($urandom);
            req_cfg[i*2 +: 2]    = 2'($urandom);
        end
        spi_slv_addr = AWIDTH'($urandom);
        spi_slv_data = DWIDTH'($urandom);
    endtask

    task automatic wait_men(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (master_en) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("launch_wait_expired", 64'd0, 64'd1);
    endtask

    // Wait for the launch, answer d cycles later with driver_read
    task automatic serve(input int d);
        bit ok;
        wait_men(ok);
        tick(d);
        driver_read = 1'b1;
        tick(1);
        driver_read = 1'b0;
    endtask

    initial begin
        bit ok;
        int gc, mc, dc, n, lc;
        bit seen, e;

        randomize_data();
        tick(1);
        // reset values
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_drv", 64'(driver_data), 64'd0);
        rst_n = 1'b1;

        // single requester, read 10 cycles after launch
        spi_slv_data = 8'hA5;
        req = 4'b0001;
        wait_men(ok);
        gc = 0; mc = 0; dc = 0;
        for (int i = 0; i < 16; i++) begin
            if (gnt == 4'b0001) gc++;
            if (master_en) mc++;
            if (done[0]) dc++;
            driver_read = (i == 10);
            if (i == 4) req = '0;
            @(negedge clk);
        end
        driver_read = 1'b0;
        chk("s1_gnt_cycles", 64'(gc), 64'd12);
        chk("s1_men_pulses", 64'(mc), 64'd1);
        chk("s1_done_pulses", 64'(dc), 64'd1);
        chk("s1_rsp_data", 64'(rsp_data), 64'hA5);
        chk("s1_drv_data", 64'(driver_data), 64'(req_data[0 +: FW]));

        // all requesting: round-robin order 0,1,2,3,0
        do_reset();
        randomize_data();
        qg.delete();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) serve(int'($urandom_range(1, 4)));
        req = '0;
        tick(3);
        chk("s2_count", 64'(qg.size()), 64'd5);
        if (qg.size() >= 5) begin
            chk("s2_g0", 64'(qg[0]), 64'd0);
            chk("s2_g1", 64'(qg[1]), 64'd1);
            chk("s2_g2", 64'(qg[2]), 64'd2);
            chk("s2_g3", 64'(qg[3]), 64'd3);
            chk("s2_g4", 64'(qg[4]), 64'd0);
        end

        // req[2] dropped during BUSY; transfer still completes
        do_reset();
        qg.delete(); qd.delete();
        req = 4'b0100;
        wait_men(ok);
        tick(2);
        req = 4'b1001;
        tick(1);
        driver_read = 1'b1;
        tick(1);
        driver_read = 1'b0;
        serve(2);
        req = '0;
        tick(3);
        chk("s3_ngrant", 64'(qg.size()), 64'd2);
        chk("s3_ndone", 64'(qd.size()), 64'd2);
        if (qg.size() == 2 && qd.size() == 2) begin
            chk("s3_done2", 64'(qd[0]), 64'd2);
            chk("s3_next", 64'(qg[1]), 64'd3);
        end

        // reset during BUSY
        req = 4'b0010;
        wait_men(ok);
        qd.delete();
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("s4_gnt", 64'(gnt), 64'd0);
        chk("s4_men", 64'(master_en), 64'd0);
        chk("s4_done", 64'(done), 64'd0);
        chk("s4_drv", 64'(driver_data), 64'd0);
        chk("s4_rsp", 64'({rsp_addr, rsp_data}), 64'd0);
        req = 4'b1111;
        tick(2);
        chk("s4_nodone", 64'(qd.size()), 64'd0);
        qg.delete();
        rst_n = 1'b1;
        serve(1);
        req = '0;
        tick(3);
        if (qg.size() > 0) chk("s4_first", 64'(qg[0]), 64'd0);
        else chk("s4_first_missing", 64'd0, 64'd1);

        // driver_read in IDLE is ignored
        tick(2);
        lc = 0;
        driver_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (gnt != 0 || done != 0) lc++;
        end
        driver_read = 1'b0;
        chk("s5_idle_read", 64'(lc), 64'd0);

        // no driver_read: timeout or wait forever
        req = 4'b0001;
        wait_men(ok);
        req = '0;
        seen = 0; n = 0; e = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (done != 0) begin seen = 1; n = i; e = err; end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        chk("s6_tmo_cycle", 64'(n), 64'd17);
        chk("s6_tmo_err", 64'(e), 64'd1);
        chk("s6_tmo_rsp", 64'(rsp_data), 64'd0);
`else
        chk("s6_no_done", 64'(seen), 64'd0);
        chk("s6_still_gnt", 64'(gnt), 64'b0001);
        driver_read = 1'b1;
        tick(1);
        driver_read = 1'b0;
`endif
        tick(3);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            randomize_data();
            req         = NREQ'($urandom) & NREQ'($urandom);
            driver_read = ($urandom_range(0, 4) == 0);
            rst_n       = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
        driver_read = 1'b0;
        req = '0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
